// File: rtl/redundancy_selector.sv
// N-way hot-standby selector: conditions per-channel fault lines, counts fault episodes
// and picks the active channel using health, hysteresis, dwell and a forced override.
module redundancy_selector #(
    parameter int unsigned NCH      = 2,
    parameter int unsigned CW       = 3,
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned HYST     = 2,
    parameter int unsigned DWELL    = 1024,
    parameter int unsigned RESET_CH = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH-1:0]       fault_i,
    input  logic                 force_i,
    input  logic [CW-1:0]        force_ch_i,
    input  logic                 release_i,
    output logic [CW-1:0]        sel_o,
    output logic [NCH-1:0]       sel_onehot_o,
    output logic                 switch_evt_o,
    output logic [1:0]           mode_o,
    output logic                 all_fault_o,
    output logic [NCH*CNT_W-1:0] err_cnt_o
);
    localparam int unsigned DW_W = (DWELL < 1) ? 1 : $clog2(DWELL + 1);
    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ModeAuto     = 2'b00,
        ModeForced   = 2'b01,
        ModeAllFault = 2'b10
    } mode_e;

    logic [NCH-1:0]   s1_q, s2_q, s3_q;
    logic [NCH-1:0]   fault_s, rise;
    logic [CNT_W-1:0] cnt_q [NCH];
    logic [CNT_W-1:0] cnt_d [NCH];
    logic [CW-1:0]    sel_q, sel_d;
    logic [NCH-1:0]   onehot_q, onehot_d;
    mode_e            mode_q, mode_d;
    logic [DW_W-1:0]  dwell_q, dwell_d;
    logic             evt_q, evt_d;
    logic             all_fault_q, all_fault_d;

    logic [CW-1:0]    best_ch;
    logic [CNT_W-1:0] best_cnt;
    logic [CNT_W-1:0] sel_cnt;
    logic             best_found;
    logic             sel_faulted;
    logic             force_ok;
    logic             any_sat;
    logic             all_faulted;
    logic             margin_ok;

    assign fault_s     = s2_q;
    assign rise        = s2_q & ~s3_q;
    assign all_faulted = &fault_s;

    // Channel scan: best healthy candidate, current channel status, force legality.
    always_comb begin
        best_ch     = sel_q;
        best_cnt    = '0;
        best_found  = 1'b0;
        sel_cnt     = '0;
        sel_faulted = 1'b0;
        force_ok    = 1'b0;
        any_sat     = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            if (!fault_s[c] && (!best_found || cnt_q[c] < best_cnt)) begin
                best_found = 1'b1;
                best_ch    = CW'(c);
                best_cnt   = cnt_q[c];
            end
            if (sel_q == CW'(c)) begin
                sel_cnt     = cnt_q[c];
                sel_faulted = fault_s[c];
            end
            if (force_i && force_ch_i == CW'(c) && !fault_s[c]) begin
                force_ok = 1'b1;
            end
            if (cnt_q[c] == CntMax) begin
                any_sat = 1'b1;
            end
        end
        margin_ok = 32'(sel_cnt) >= 32'(best_cnt) + HYST;
    end

    always_comb begin
        sel_d  = sel_q;
        mode_d = mode_q;
        if (force_ok) begin
            sel_d  = force_ch_i;
            mode_d = ModeForced;
        end else begin
            unique case (mode_q)
                ModeAuto: begin
                    if (all_faulted) begin
                        mode_d = ModeAllFault;
                    end else if (sel_faulted) begin
                        sel_d = best_ch;
                    end else if (dwell_q == '0 && margin_ok) begin
                        sel_d = best_ch;
                    end
                end
                ModeForced: begin
                    if (sel_faulted) begin
                        if (all_faulted) begin
                            mode_d = ModeAllFault;
                        end else begin
                            sel_d  = best_ch;
                            mode_d = ModeAuto;
                        end
                    end else if (release_i) begin
                        mode_d = ModeAuto;
                    end
                end
                ModeAllFault: begin
                    if (!all_faulted) begin
                        sel_d  = best_ch;
                        mode_d = ModeAuto;
                    end
                end
                default: mode_d = ModeAuto;
            endcase
        end

        evt_d       = (sel_d != sel_q);
        all_fault_d = (mode_d == ModeAllFault);

        // A forced write re-arms the dwell even when the channel does not change.
        if (force_ok || evt_d) begin
            dwell_d = DW_W'(DWELL);
        end else if (dwell_q != '0) begin
            dwell_d = dwell_q - DW_W'(1);
        end else begin
            dwell_d = dwell_q;
        end

        for (int c = 0; c < NCH; c++) begin
            onehot_d[c] = (sel_d == CW'(c));
        end
    end

    // Halving on saturation keeps the relative ordering between channels.
    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            if (force_ok) begin
                cnt_d[c] = '0;
            end else if (any_sat) begin
                cnt_d[c] = (cnt_q[c] >> 1) + CNT_W'(rise[c]);
            end else begin
                cnt_d[c] = cnt_q[c] + CNT_W'(rise[c]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q        <= '0;
            s2_q        <= '0;
            s3_q        <= '0;
            sel_q       <= CW'(RESET_CH);
            onehot_q    <= NCH'(1) << RESET_CH;
            mode_q      <= ModeAuto;
            dwell_q     <= '0;
            evt_q       <= 1'b0;
            all_fault_q <= 1'b0;
            for (int c = 0; c < NCH; c++) begin
                cnt_q[c] <= '0;
            end
        end else begin
            s1_q        <= fault_i;
            s2_q        <= s1_q;
            s3_q        <= s2_q;
            sel_q       <= sel_d;
            onehot_q    <= onehot_d;
            mode_q      <= mode_d;
            dwell_q     <= dwell_d;
            evt_q       <= evt_d;
            all_fault_q <= all_fault_d;
            for (int c = 0; c < NCH; c++) begin
                cnt_q[c] <= cnt_d[c];
            end
        end
    end

    assign sel_o        = sel_q;
    assign sel_onehot_o = onehot_q;
    assign switch_evt_o = evt_q;
    assign mode_o       = mode_q;
    assign all_fault_o  = all_fault_q;

    for (genvar g = 0; g < NCH; g++) begin : g_cnt_out
        assign err_cnt_o[g*CNT_W +: CNT_W] = cnt_q[g];
    end

endmodule

// File: tb/tb_redundancy_selector.sv
// Directed bench for redundancy_selector with NCH=3, CNT_W=4, HYST=2, DWELL=8.
module tb_redundancy_selector;
    localparam int unsigned NCH   = 3;
    localparam int unsigned CW    = 3;
    localparam int unsigned CNT_W = 4;

    logic                 clk;
    logic                 rst;
    logic [NCH-1:0]       fault;
    logic                 force_cmd;
    logic [CW-1:0]        force_ch;
    logic                 release_cmd;
    logic [CW-1:0]        sel;
    logic [NCH-1:0]       sel_onehot;
    logic                 switch_evt;
    logic [1:0]           mode;
    logic                 all_fault;
    logic [NCH*CNT_W-1:0] err_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    redundancy_selector #(
        .NCH     (NCH),
        .CW      (CW),
        .CNT_W   (CNT_W),
        .HYST    (2),
        .DWELL   (8),
        .RESET_CH(0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .fault_i     (fault),
        .force_i     (force_cmd),
        .force_ch_i  (force_ch),
        .release_i   (release_cmd),
        .sel_o       (sel),
        .sel_onehot_o(sel_onehot),
        .switch_evt_o(switch_evt),
        .mode_o      (mode),
        .all_fault_o (all_fault),
        .err_cnt_o   (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // One-cycle fault pulse, then let the synchroniser drain so the rise is counted.
    task automatic pulse(input logic [NCH-1:0] mask);
        fault = mask;
        tick();
        fault = '0;
        tick(3);
    endtask

    task automatic do_force(input logic [CW-1:0] ch);
        force_cmd = 1'b1;
        force_ch  = ch;
        tick();
        force_cmd = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        fault       = '0;
        force_cmd   = 1'b0;
        force_ch    = '0;
        release_cmd = 1'b0;
        tick(2);
        rst = 1'b0;
        chk("rst_sel", sel, 0);
        chk("rst_onehot", sel_onehot, 3'b001);
        chk("rst_mode", mode, 2'b00);
        chk("rst_cnt", err_cnt, 0);
        chk("rst_evt", switch_evt, 0);
        chk("rst_allf", all_fault, 0);

        // Fault on the active channel: switch three edges after the input change.
        fault = 3'b001;
        tick(2);
        chk("lat_hold", sel, 0);
        tick();
        chk("f0_sel", sel, 1);
        chk("f0_evt", switch_evt, 1);
        chk("f0_onehot", sel_onehot, 3'b010);
        chk("f0_cnt", err_cnt, 12'h001);
        tick();
        chk("f0_evt_drop", switch_evt, 0);

        fault = '0;
        tick(3);
        pulse(3'b001);
        pulse(3'b001);
        chk("p0_sel", sel, 1);
        chk("p0_cnt", err_cnt, 12'h003);

        // Move onto ch0 (cnt 3) while ch1/ch2 sit at 1: margin 2 waits for dwell.
        fault = 3'b110;
        tick(3);
        chk("hy_sel0", sel, 0);
        chk("hy_cnt", err_cnt, 12'h113);
        fault = '0;
        tick(8);
        chk("dwell_block", sel, 0);
        tick();
        chk("hy_sel1", sel, 1);
        chk("hy_evt", switch_evt, 1);

        // Back to ch0 with margin 1 only: no comparative switch after dwell.
        fault = 3'b110;
        tick(3);
        chk("m1_sel0", sel, 0);
        chk("m1_cnt", err_cnt, 12'h223);
        fault = '0;
        tick(20);
        chk("m1_hold", sel, 0);
        chk("m1_mode", mode, 2'b00);

        // Force onto the already-active channel: clears counters, no switch pulse.
        do_force(3'd0);
        chk("fsame_sel", sel, 0);
        chk("fsame_evt", switch_evt, 0);
        chk("fsame_mode", mode, 2'b01);
        chk("fsame_cnt", err_cnt, 0);

        // Saturation: 15 ch2 episodes, 4 ch1 episodes, then one ch1 rise on halving.
        for (int i = 0; i < 31; i++) begin
            fault[0] = 1'b0;
            fault[1] = ((i % 2 == 0) && (i < 8)) || (i == 29);
            fault[2] = (i % 2 == 0) && (i < 30);
            tick();
        end
        chk("sat_full", err_cnt, 12'hF40);
        fault = '0;
        tick();
        chk("sat_half", err_cnt, 12'h730);
        chk("sat_mode", mode, 2'b01);
        chk("sat_sel", sel, 0);

        do_force(3'd2);
        chk("f2_sel", sel, 2);
        chk("f2_mode", mode, 2'b01);
        chk("f2_evt", switch_evt, 1);
        chk("f2_onehot", sel_onehot, 3'b100);
        chk("f2_cnt", err_cnt, 0);

        pulse(3'b010);
        chk("f2_p1", err_cnt, 12'h010);
        do_force(3'd3);
        chk("fbad_sel", sel, 2);
        chk("fbad_cnt", err_cnt, 12'h010);
        chk("fbad_evt", switch_evt, 0);

        fault = 3'b001;
        tick(3);
        chk("ff_cnt", err_cnt, 12'h011);
        do_force(3'd0);
        chk("ffault_sel", sel, 2);
        chk("ffault_cnt", err_cnt, 12'h011);
        chk("ffault_mode", mode, 2'b01);

        // Fault the forced channel: back to AUTO on the healthiest (tie -> ch0).
        fault = 3'b100;
        tick(2);
        chk("fx_hold", sel, 2);
        tick();
        chk("fx_sel", sel, 0);
        chk("fx_mode", mode, 2'b00);
        chk("fx_evt", switch_evt, 1);
        chk("fx_cnt", err_cnt, 12'h111);

        fault = 3'b111;
        tick(2);
        chk("af_pre", mode, 2'b00);
        tick();
        chk("af_mode", mode, 2'b10);
        chk("af_flag", all_fault, 1);
        chk("af_sel", sel, 0);
        chk("af_cnt", err_cnt, 12'h122);

        fault = 3'b101;
        tick(2);
        chk("af_stay", mode, 2'b10);
        tick();
        chk("afx_sel", sel, 1);
        chk("afx_mode", mode, 2'b00);
        chk("afx_flag", all_fault, 0);
        chk("afx_evt", switch_evt, 1);

        do_force(3'd1);
        chk("fr_mode", mode, 2'b01);
        release_cmd = 1'b1;
        tick();
        release_cmd = 1'b0;
        chk("rel_mode", mode, 2'b00);
        chk("rel_sel", sel, 1);

        do_force(3'd1);
        force_cmd   = 1'b1;
        force_ch    = 3'd1;
        release_cmd = 1'b1;
        tick();
        force_cmd   = 1'b0;
        release_cmd = 1'b0;
        chk("fwin_mode", mode, 2'b01);
        tick(2);
        chk("fwin_hold", mode, 2'b01);

        // Reset in the middle of a dwell window.
        rst   = 1'b1;
        fault = '0;
        tick();
        chk("rst2_sel", sel, 0);
        chk("rst2_onehot", sel_onehot, 3'b001);
        chk("rst2_mode", mode, 2'b00);
        chk("rst2_evt", switch_evt, 0);
        chk("rst2_cnt", err_cnt, 0);
        chk("rst2_allf", all_fault, 0);
        rst = 1'b0;
        tick(12);
        chk("post_sel", sel, 0);
        chk("post_mode", mode, 2'b00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
